hi_lo_muldiv_sequencer: RTL
===========================

// Module: hi_lo_muldiv_sequencer
// PURPOSE
//  Owns the HI/LO register pair and sequences iterative MULT/MULTU/DIV/DIVU/MADD/MSUB/MTHI/MTLO.
//  Sits beside EX. Its ReadDataHi/ReadDataLo feed the write-back HI/LO select path.
//  Produces Stall for the hazard unit whenever a new HI/LO op or an MFHI/MFLO meets a busy unit.
// PARAMETERS
//  DATA_WIDTH  32  operand / HI / LO width
//  CNT_WIDTH   6   iteration counter width (must hold DATA_WIDTH)
// PORTS
//  Clk          in   1   clock, rising edge
//  Rst          in   1   asynchronous active-low reset
//  Start        in   1   HI/LO op issued this cycle (EX stage)
//  Op           in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MSUB,6 MTHI,7 MTLO
//  OpA          in   32  rs value (dividend / multiplicand / MTHI-MTLO data)
//  OpB          in   32  rt value (divisor / multiplier)
//  ReadReq      in   1   MFHI/MFLO present in EX this cycle
//  Flush        in   1   abort in-flight op (branch/exception squash)
//  ReadDataHi   out  32  current HI
//  ReadDataLo   out  32  current LO
//  Busy         out  1   iterative op in flight
//  Stall        out  1   hold pipeline; = Busy & (Start | ReadReq)
//  Done         out  1   one-cycle pulse, HI/LO just updated by iterative op
//  DivByZero    out  1   one-cycle pulse, DIV/DIVU with OpB==0 accepted
// BEHAVIOUR
//  Reset (async, Rst=0): state IDLE, HI=LO=0, counter=0, Busy=Stall=Done=DivByZero=0.
//  States: IDLE, MUL, DIV, FIXUP, ACC.
//  IDLE + Start: MTHI/MTLO write HI/LO at that edge, no Busy, 1-cycle op.
//   MULT*/MADD/MSUB -> MUL; DIV* with OpB!=0 -> DIV; counter loads 0.
//   Signed ops latch |OpA|,|OpB| plus result sign(s); unsigned ops latch raw.
//  MUL: shift-add one multiplier bit per edge, 32 edges -> FIXUP.
//  DIV: restoring, one quotient bit per edge, 32 edges -> FIXUP.
//  FIXUP: apply sign (product negated if signs differ; quotient negated if signs differ;
//   remainder takes dividend sign). Then write HI/LO (mul: HI=prod[63:32], LO=prod[31:0];
//   div: LO=quotient, HI=remainder), pulse Done, -> IDLE.
//   MADD/MSUB skip the write and go to ACC.
//  ACC: {HI,LO} <= {HI,LO} +/- 64-bit signed product, pulse Done, -> IDLE.
//  Latency from accepting edge E0: Busy=1 after E0. MUL/DIV 33 cycles, MADD/MSUB 34.
//   Result readable (ReadDataHi/Lo) the cycle after the last edge; Busy drops in the same cycle.
//  DIV/DIVU OpB==0: no iteration. LO=32'hFFFFFFFF, HI=OpA at E0, DivByZero pulse, no Busy.
//  Start while Busy: not accepted, Stall=1. Issuer holds Op/OpA/OpB until Stall=0, then accepted.
//  ReadReq while Busy: Stall=1, HI/LO unchanged. Same-cycle Done+ReadReq: Busy already 0,
//   no stall, reads new value.
//  Start and ReadReq both in IDLE: Start executes. Pipeline order guarantees that ReadReq
//   belongs to an older instruction and sees pre-write HI/LO.
//  Flush: priority over everything except reset. Next edge -> IDLE; HI/LO untouched;
//   Busy=0, no Done. A Start in the same cycle as Flush is dropped.
//  All HI/LO arithmetic is modulo 2^64. Most-negative / -1 division wraps (LO=8000_0000, HI=0).
// STRUCTURE
//  Shared include hilo_defs.vh: Op encodings (OP_MULT..OP_MTLO), state encodings, ITER_COUNT=32.
//  One sub-module, hilo_iter_unit: 64-bit shift-add/shift-subtract step datapath
//   (mode, step, partial regs in, partial regs out). FSM, sign fixup and HI/LO regs stay in top.
// TESTING
//  MULT 6,7 -> Busy 33 cycles, Done pulse, HI=0, LO=42.
//  MULT -3(FFFFFFFD),5 -> HI=FFFFFFFF, LO=FFFFFFF1; MULTU same operands -> HI=4, LO=FFFFFFF1.
//  DIVU 100,7 -> LO=14, HI=2; DIV -7,2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIV x,0 -> DivByZero, LO=FFFFFFFF, HI=x, 0 Busy.
//  MTLO 5, then MADD 2,3 -> LO=11, HI=0 after 34 cycles; MSUB 4,4 -> {HI,LO}=FFFFFFFF_FFFFFFFB.
//  ReadReq at cycle 10 of MULT -> Stall until Busy drops; back-to-back Start held -> accepted on Done cycle.
//  Rst low or Flush at cycle 15 of DIV -> IDLE, Busy=0, no Done, HI/LO equal pre-op values (reset: 0).

Source files
------------

// File: rtl/hi_lo_muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// operation and state encodings plus small op-classification helpers.
package hi_lo_muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MSUB  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } opE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_ACC   = 3'd4
    } stateE;

    // One iteration per operand bit.
    localparam int ITER_COUNT = 32;

    function automatic logic isSignedOp(input opE op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic isMulOp(input opE op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic isDivOp(input opE op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hi_lo_muldiv_sequencer_iter.sv
// HI/LO iteration step datapath: one shift-add multiply step or one
// restoring shift-subtract divide step on the {partHi, partLo} pair.
// Multiply: partLo holds the multiplier, operand the multiplicand.
// Divide:   partLo holds the dividend/quotient, partHi the remainder,
//           operand the divisor.
module hi_lo_muldiv_sequencer_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  divMode,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] partHiIn,
    input  logic [DATA_WIDTH-1:0] partLoIn,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] partHiOut,
    output logic [DATA_WIDTH-1:0] partLoOut
);
    localparam int W = DATA_WIDTH;

    logic [W:0] mulSum;
    logic [W:0] divShift;
    logic [W:0] divTrial;

    // Single iteration; partials pass through unchanged when step is low.
    always_comb begin
        partHiOut = partHiIn;
        partLoOut = partLoIn;
        mulSum    = {1'b0, partHiIn} + (partLoIn[0] ? {1'b0, operand} : '0);
        divShift  = {partHiIn, partLoIn[W-1]};
        divTrial  = divShift - {1'b0, operand};
        if (step) begin
            if (divMode) begin
                // Negative trial (top bit set) means the divisor did not fit.
                if (divTrial[W]) begin
                    partHiOut = divShift[W-1:0];
                    partLoOut = {partLoIn[W-2:0], 1'b0};
                end else begin
                    partHiOut = divTrial[W-1:0];
                    partLoOut = {partLoIn[W-2:0], 1'b1};
                end
            end else begin
                partHiOut = mulSum[W:1];
                partLoOut = {mulSum[0], partLoIn[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/hi_lo_muldiv_sequencer.sv
// HI/LO register pair owner sitting beside EX. Sequences iterative
// multiply/divide (32 steps + sign fixup, plus an accumulate step for
// MADD/MSUB), handles single-cycle MTHI/MTLO and divide-by-zero, and
// raises Stall when a HI/LO op or MFHI/MFLO meets a busy unit.
module hi_lo_muldiv_sequencer
    import hi_lo_muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] OpA,
    input  logic [DATA_WIDTH-1:0] OpB,
    input  logic                  ReadReq,
    input  logic                  Flush,
    output logic [DATA_WIDTH-1:0] ReadDataHi,
    output logic [DATA_WIDTH-1:0] ReadDataLo,
    output logic                  Busy,
    output logic                  Stall,
    output logic                  Done,
    output logic                  DivByZero
);
    localparam int W = DATA_WIDTH;

    stateE                state, nextState;
    opE                   opIn, opReg;
    logic [CNT_WIDTH-1:0] iterCnt;
    logic [W-1:0]         hiReg, loReg;
    logic [W-1:0]         partHi, partLo, operand, stepHi, stepLo;
    logic [W-1:0]         absA, absB, fixQuot, fixRem;
    logic [2*W-1:0]       prod, fixProd, accSum;
    logic                 negRes, negRem, signedIn;
    logic                 accept, acceptMul, acceptDiv, acceptDbz;
    logic                 lastIter, iterating, accOp, writeFix, writeAcc;

    assign opIn       = opE'(Op);
    assign ReadDataHi = hiReg;
    assign ReadDataLo = loReg;

    // Signed ops iterate on magnitudes; the signs are re-applied in FIXUP.
    assign signedIn = isSignedOp(opIn);
    assign absA     = (signedIn && OpA[W-1]) ? -OpA : OpA;
    assign absB     = (signedIn && OpB[W-1]) ? -OpB : OpB;

    assign acceptMul = accept && isMulOp(opIn);
    assign acceptDiv = accept && isDivOp(opIn) && (OpB != '0);
    assign acceptDbz = accept && isDivOp(opIn) && (OpB == '0);

    assign iterating = (state == ST_MUL) || (state == ST_DIV);
    assign lastIter  = (iterCnt == CNT_WIDTH'(ITER_COUNT - 1));
    assign accOp     = (opReg == OP_MADD) || (opReg == OP_MSUB);
    assign writeFix  = (state == ST_FIXUP) && !accOp && !Flush;
    assign writeAcc  = (state == ST_ACC) && !Flush;

    // Sign fixup and accumulate arithmetic, all modulo 2^(2W).
    assign prod    = {partHi, partLo};
    assign fixProd = negRes ? -prod : prod;
    assign fixQuot = negRes ? -partLo : partLo;
    assign fixRem  = negRem ? -partHi : partHi;
    assign accSum  = (opReg == OP_MSUB) ? ({hiReg, loReg} - prod) : ({hiReg, loReg} + prod);

    hi_lo_muldiv_sequencer_iter #(
        .DATA_WIDTH(W)
    ) uIter (
        .divMode  (state == ST_DIV),
        .step     (iterating),
        .partHiIn (partHi),
        .partLoIn (partLo),
        .operand  (operand),
        .partHiOut(stepHi),
        .partLoOut(stepLo)
    );

    // Next-state, accept and stall decode; Flush overrides everything.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        Busy      = (state != ST_IDLE);
        Stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = Start;
                if (Start && isMulOp(opIn)) begin
                    nextState = ST_MUL;
                end else if (Start && isDivOp(opIn) && (OpB != '0)) begin
                    nextState = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (lastIter) nextState = ST_FIXUP;
            end
            ST_FIXUP: nextState = accOp ? ST_ACC : ST_IDLE;
            ST_ACC:   nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
        Stall = Busy && (Start || ReadReq);
        if (Flush) begin
            nextState = ST_IDLE;
            accept    = 1'b0;
        end
    end

    // State register, iteration counter and result pulses.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= ST_IDLE;
            iterCnt   <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            state     <= nextState;
            Done      <= writeFix || writeAcc;
            DivByZero <= acceptDbz;
            if (accept) begin
                iterCnt <= '0;
            end else if (iterating) begin
                iterCnt <= iterCnt + CNT_WIDTH'(1);
            end
        end
    end

    // Architectural HI/LO: direct moves, divide-by-zero, fixup and accumulate writes.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (accept && (opIn == OP_MTHI)) begin
            hiReg <= OpA;
        end else if (accept && (opIn == OP_MTLO)) begin
            loReg <= OpA;
        end else if (acceptDbz) begin
            hiReg <= OpA;
            loReg <= '1;
        end else if (writeFix) begin
            if ((opReg == OP_DIV) || (opReg == OP_DIVU)) begin
                hiReg <= fixRem;
                loReg <= fixQuot;
            end else begin
                {hiReg, loReg} <= fixProd;
            end
        end else if (writeAcc) begin
            {hiReg, loReg} <= accSum;
        end
    end

    // Iteration partials: loaded on accept, stepped while iterating,
    // and holding the signed product between FIXUP and ACC.
    always_ff @(posedge Clk) begin
        if (acceptMul || acceptDiv) begin
            opReg   <= opIn;
            partHi  <= '0;
            partLo  <= acceptMul ? absB : absA;
            operand <= acceptMul ? absA : absB;
            negRes  <= signedIn && (OpA[W-1] ^ OpB[W-1]);
            negRem  <= signedIn && OpA[W-1];
        end else if (iterating) begin
            partHi <= stepHi;
            partLo <= stepLo;
        end else if ((state == ST_FIXUP) && accOp) begin
            {partHi, partLo} <= fixProd;
        end
    end

endmodule
